urv_dm_wb_bridge: RTL

//  Bridges the uRV data-memory port (dm_* signals of the CPU) to a pipelined Wishbone B4 master.

---
 rtl/urv_dm_wb_bridge.sv | 135 +++++++++++++
 1 files changed

// File: rtl/urv_dm_wb_bridge.sv
// uRV data-memory port to pipelined Wishbone B4 master bridge.
// One single-beat bus cycle per load/store strobe, with bus timeout and sticky error capture.
//
// state | meaning
// IDLE  | ready, waiting for a load/store strobe
// REQ   | cyc=stb=1, waiting for the slave to drop stall
// WAIT  | cyc=1, stb=0, waiting for ack/err
// DONE  | one-cycle done pulse; a new request may be accepted here
module urv_dm_wb_bridge #(
  parameter int unsigned g_timeout_cycles = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_stall_i,
  output logic        bus_err_o,
  output logic [31:0] bus_err_addr_o,
  input  logic        bus_err_clr_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;

  localparam bit          c_to_en   = (g_timeout_cycles != 0);
  localparam logic [15:0] c_to_last = c_to_en ? 16'(g_timeout_cycles - 1) : 16'd0;

  state_t      state_q, state_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d, data_l_q, data_l_d, err_addr_q, err_addr_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d, bus_err_q, bus_err_d;
  logic [15:0] cnt_q, cnt_d;
  logic        busy, accept, timeout, fail, complete;

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    data_l_d   = data_l_q;
    bus_err_d  = bus_err_q;
    err_addr_d = err_addr_q;

    busy     = (state_q == ST_REQ) || (state_q == ST_WAIT);
    accept   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && (dm_store_i || dm_load_i);
    timeout  = c_to_en && busy && (cnt_q == c_to_last) && !wb_ack_i && !wb_err_i;
    fail     = busy && (wb_err_i || timeout);
    complete = busy && (wb_ack_i || wb_err_i || timeout);

    unique case (state_q)
      ST_IDLE, ST_DONE: state_d = accept ? ST_REQ : ST_IDLE;
      ST_REQ: begin
        if (complete)         state_d = ST_DONE;
        else if (!wb_stall_i) state_d = ST_WAIT;
      end
      ST_WAIT: if (complete) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      adr_d = dm_addr_i;
      dat_d = dm_data_s_i;
      sel_d = dm_data_select_i;
      we_d  = dm_store_i;
      cnt_d = 16'd0;
    end else if (busy) begin
      cnt_d = cnt_q + 16'd1;
    end

    if (busy && wb_ack_i && !wb_err_i && !we_q) data_l_d = wb_dat_i;
    if (fail && !we_q)                            data_l_d = 32'd0;

    // A new failure overrides a simultaneous clear; only the first address is kept.
    if (bus_err_clr_i) bus_err_d = 1'b0;
    if (fail) begin
      bus_err_d = 1'b1;
      if (!bus_err_q) err_addr_d = adr_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      data_l_q   <= '0;
      bus_err_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      data_l_q   <= data_l_d;
      bus_err_q  <= bus_err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign dm_ready_o      = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign dm_load_done_o  = (state_q == ST_DONE) && !we_q;
  assign dm_store_done_o = (state_q == ST_DONE) && we_q;
  assign dm_data_l_o     = data_l_q;
  assign wb_adr_o        = adr_q;
  assign wb_dat_o        = dat_q;
  assign wb_sel_o        = sel_q;
  assign wb_we_o         = we_q;
  assign wb_cyc_o        = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign wb_stb_o        = (state_q == ST_REQ);
  assign bus_err_o       = bus_err_q;
  assign bus_err_addr_o  = err_addr_q;

endmodule
